// File: rtl/btn_event_pkg.sv
// -----------------------------------------------------------------------------
// btn_event_pkg
//   Shared definitions for the front-panel button path: the decoder state
//   encoding (also consumed by the mode-control FSM and the debug LEDs) and the
//   default timing constants for a 100 MHz system clock.
// -----------------------------------------------------------------------------
package btn_event_pkg;

  // Encoding is visible on o_state, so the values are fixed explicitly.
  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_PRESSED   = 2'd1,
    ST_LONG_HELD = 2'd2,
    ST_UNUSED    = 2'd3
  } btn_state_t;

  // Defaults at 100 MHz: long press after 0.5 s, auto-repeat every 0.1 s.
  localparam int unsigned DEF_CNT_W          = 26;
  localparam logic [25:0] DEF_LONG_CYCLES    = 26'd50_000_000;
  localparam logic [25:0] DEF_REPEAT_CYCLES  = 26'd10_000_000;

endpackage : btn_event_pkg

// File: rtl/btn_edge_detect.sv
// -----------------------------------------------------------------------------
// btn_edge_detect
//   One-cycle delayed copy of a synchronous level plus combinational rise/fall
//   strobes. Reusable for any panel input already in the i_clk domain.
// Ports
//   i_clk    in  1  system clock
//   i_reset  in  1  synchronous, active-high reset (clears the delayed copy)
//   i_btn    in  1  synchronous level (1 = asserted)
//   o_rise   out 1  i_btn & ~previous level
//   o_fall   out 1  ~i_btn & previous level
// -----------------------------------------------------------------------------
module btn_edge_detect (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn,
  output logic o_rise,
  output logic o_fall
);

  logic r_btn_d;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_btn_d <= 1'b0;
    end else begin
      r_btn_d <= i_btn;
    end
  end

  // Clearing r_btn_d on reset makes a level still held after reset look like a
  // fresh press on the first post-reset edge.
  assign o_rise = i_btn & ~r_btn_d;
  assign o_fall = ~i_btn & r_btn_d;

endmodule : btn_edge_detect

// File: rtl/button_event_decoder.sv
// -----------------------------------------------------------------------------
// button_event_decoder
//   Turns a debounced button level into single-cycle events for the controller:
//   press, short-press, long-press, auto-repeat and release. All event outputs
//   are registered; only o_short and o_release may be high together.
// Parameters
//   CNT_W          counter width, must hold max(LONG_CYCLES,REPEAT_CYCLES)-1
//   LONG_CYCLES    cycles from o_press to o_long (>=2)
//   REPEAT_CYCLES  o_repeat period while long-held (>=1)
//   REPEAT_EN      1 = generate o_repeat, 0 = o_repeat stays low
// Ports
//   i_clk      in  1  system clock
//   i_reset    in  1  synchronous, active-high reset
//   i_btn      in  1  debounced level (1 = pressed), synchronous to i_clk
//   o_press    out 1  pulse on press
//   o_short    out 1  pulse on release before o_long fired
//   o_long     out 1  pulse when the hold reaches LONG_CYCLES
//   o_repeat   out 1  pulse every REPEAT_CYCLES while long-held
//   o_release  out 1  pulse on any release
//   o_state    out 2  current state (IDLE=0, PRESSED=1, LONG_HELD=2)
// -----------------------------------------------------------------------------
module button_event_decoder
  import btn_event_pkg::*;
#(
  parameter int unsigned          CNT_W         = DEF_CNT_W,
  parameter logic [CNT_W-1:0]     LONG_CYCLES   = CNT_W'(DEF_LONG_CYCLES),
  parameter logic [CNT_W-1:0]     REPEAT_CYCLES = CNT_W'(DEF_REPEAT_CYCLES),
  parameter bit                   REPEAT_EN     = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn,
  output logic       o_press,
  output logic       o_short,
  output logic       o_long,
  output logic       o_repeat,
  output logic       o_release,
  output logic [1:0] o_state
);

  localparam logic [CNT_W-1:0] LONG_LAST   = LONG_CYCLES - CNT_W'(1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = REPEAT_CYCLES - CNT_W'(1);

  logic             w_rise;
  logic             w_fall;

  btn_state_t       r_state;
  btn_state_t       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  logic r_press,   w_press_nxt;
  logic r_short,   w_short_nxt;
  logic r_long,    w_long_nxt;
  logic r_repeat,  w_repeat_nxt;
  logic r_release, w_release_nxt;

  btn_edge_detect u_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_btn   (i_btn),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_short   <= 1'b0;
      r_long    <= 1'b0;
      r_repeat  <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_short   <= w_short_nxt;
      r_long    <= w_long_nxt;
      r_repeat  <= w_repeat_nxt;
      r_release <= w_release_nxt;
    end
  end

  // In PRESSED/LONG_HELD the delayed level is always 1 (the state was entered
  // on a rise and is left on the first low sample), so w_fall is exactly
  // "button low" there. Testing release first gives it priority over
  // long/repeat on the same edge.
  always_comb begin
    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_short_nxt   = 1'b0;
    w_long_nxt    = 1'b0;
    w_repeat_nxt  = 1'b0;
    w_release_nxt = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
          w_press_nxt = 1'b1;
        end
      end

      ST_PRESSED: begin
        if (w_fall) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_short_nxt   = 1'b1;
          w_release_nxt = 1'b1;
        end else if (r_cnt == LONG_LAST) begin
          w_state_nxt = ST_LONG_HELD;
          w_cnt_nxt   = '0;
          w_long_nxt  = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      ST_LONG_HELD: begin
        if (w_fall) begin
          w_state_nxt   = ST_IDLE;
          w_cnt_nxt     = '0;
          w_release_nxt = 1'b1;
        end else if (r_cnt == REPEAT_LAST) begin
          // The period keeps running with REPEAT_EN=0; only the pulse is masked.
          w_cnt_nxt    = '0;
          w_repeat_nxt = REPEAT_EN;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign o_press   = r_press;
  assign o_short   = r_short;
  assign o_long    = r_long;
  assign o_repeat  = r_repeat;
  assign o_release = r_release;
  assign o_state   = r_state;

endmodule : button_event_decoder

// File: tb/tb_button_event_decoder.sv
// -----------------------------------------------------------------------------
// tb_button_event_decoder
//   Directed bench for button_event_decoder with LONG_CYCLES=8, REPEAT_CYCLES=4.
//   dut_rep has REPEAT_EN=1, dut_norep has REPEAT_EN=0. Each cycle index k is
//   the k-th rising edge of a scenario; inputs are set 1 time unit after the
//   previous edge and outputs are sampled 1 time unit after edge k.
//   Event vectors are {press, short, long, repeat, release}.
// -----------------------------------------------------------------------------
module tb_button_event_decoder;

  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_P    = 5'b10000;
  localparam logic [4:0] EV_S    = 5'b01000;
  localparam logic [4:0] EV_L    = 5'b00100;
  localparam logic [4:0] EV_R    = 5'b00010;
  localparam logic [4:0] EV_X    = 5'b00001;

  logic i_clk   = 1'b0;
  logic i_reset = 1'b1;
  logic r_btn0  = 1'b0;
  logic r_btn1  = 1'b0;

  logic       press0, short0, long0, repeat0, release0;
  logic       press1, short1, long1, repeat1, release1;
  logic [1:0] state0, state1;
  logic [4:0] w_ev0, w_ev1;

  int n_checks = 0;
  int n_errors = 0;

  always #5 i_clk = ~i_clk;

  button_event_decoder #(
    .CNT_W(26), .LONG_CYCLES(26'd8), .REPEAT_CYCLES(26'd4), .REPEAT_EN(1'b1)
  ) dut_rep (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(r_btn0),
    .o_press(press0), .o_short(short0), .o_long(long0),
    .o_repeat(repeat0), .o_release(release0), .o_state(state0)
  );

  button_event_decoder #(
    .CNT_W(26), .LONG_CYCLES(26'd8), .REPEAT_CYCLES(26'd4), .REPEAT_EN(1'b0)
  ) dut_norep (
    .i_clk(i_clk), .i_reset(i_reset), .i_btn(r_btn1),
    .o_press(press1), .o_short(short1), .o_long(long1),
    .o_repeat(repeat1), .o_release(release1), .o_state(state1)
  );

  assign w_ev0 = {press0, short0, long0, repeat0, release0};
  assign w_ev1 = {press1, short1, long1, repeat1, release1};

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input int n);
    r_btn0 = 1'b0;
    r_btn1 = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  // 1: reset held 3 cycles, then one cycle after release, everything quiet.
  task automatic test_reset();
    i_reset = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k == 3) i_reset = 1'b0;
      tick();
      n_checks++;
      if (w_ev0 !== EV_NONE || state0 !== 2'd0) begin
        n_errors++;
        $display("FAIL reset k=%0d dut_rep got ev=%b st=%0d want ev=%b st=0", k, w_ev0, state0, EV_NONE);
      end
      n_checks++;
      if (w_ev1 !== EV_NONE || state1 !== 2'd0) begin
        n_errors++;
        $display("FAIL reset k=%0d dut_norep got ev=%b st=%0d want ev=%b st=0", k, w_ev1, state1, EV_NONE);
      end
    end
  endtask

  // 2: high for 3 edges, then low: short+release 3 cycles after press.
  task automatic test_short_press();
    logic [4:0] exp_ev;
    logic [1:0] exp_st;
    for (int k = 0; k < 6; k++) begin
      r_btn0 = (k < 3);
      tick();
      exp_ev = (k == 0) ? EV_P : (k == 3) ? (EV_S | EV_X) : EV_NONE;
      exp_st = (k < 3) ? 2'd1 : 2'd0;
      n_checks++;
      if (w_ev0 !== exp_ev || state0 !== exp_st) begin
        n_errors++;
        $display("FAIL short_press k=%0d got ev=%b st=%0d want ev=%b st=%0d", k, w_ev0, state0, exp_ev, exp_st);
      end
    end
  endtask

  // 3: high for 20 edges: long at +8, repeats at +12/+16, release-only at 20
  //    (where a third repeat would otherwise have fired).
  task automatic test_long_repeat();
    logic [4:0] exp_ev;
    logic [1:0] exp_st;
    for (int k = 0; k < 24; k++) begin
      r_btn0 = (k < 20);
      tick();
      case (k)
        0:       exp_ev = EV_P;
        8:       exp_ev = EV_L;
        12, 16:  exp_ev = EV_R;
        20:      exp_ev = EV_X;
        default: exp_ev = EV_NONE;
      endcase
      exp_st = (k < 8) ? 2'd1 : (k < 20) ? 2'd2 : 2'd0;
      n_checks++;
      if (w_ev0 !== exp_ev || state0 !== exp_st) begin
        n_errors++;
        $display("FAIL long_repeat k=%0d got ev=%b st=%0d want ev=%b st=%0d", k, w_ev0, state0, exp_ev, exp_st);
      end
    end
  endtask

  // 4: release on the cnt==7 edge beats long; one edge later, long then release.
  task automatic test_long_boundary();
    logic [4:0] exp_ev;
    logic [1:0] exp_st;
    for (int k = 0; k < 11; k++) begin
      r_btn0 = (k < 8);
      tick();
      exp_ev = (k == 0) ? EV_P : (k == 8) ? (EV_S | EV_X) : EV_NONE;
      exp_st = (k < 8) ? 2'd1 : 2'd0;
      n_checks++;
      if (w_ev0 !== exp_ev || state0 !== exp_st) begin
        n_errors++;
        $display("FAIL boundary_8 k=%0d got ev=%b st=%0d want ev=%b st=%0d", k, w_ev0, state0, exp_ev, exp_st);
      end
    end
    for (int k = 0; k < 12; k++) begin
      r_btn0 = (k < 9);
      tick();
      exp_ev = (k == 0) ? EV_P : (k == 8) ? EV_L : (k == 9) ? EV_X : EV_NONE;
      exp_st = (k < 8) ? 2'd1 : (k < 9) ? 2'd2 : 2'd0;
      n_checks++;
      if (w_ev0 !== exp_ev || state0 !== exp_st) begin
        n_errors++;
        $display("FAIL boundary_9 k=%0d got ev=%b st=%0d want ev=%b st=%0d", k, w_ev0, state0, exp_ev, exp_st);
      end
    end
  endtask

  // 5: reset on edges 10-11 while long-held with the button still down:
  //    silent return to IDLE, fresh press at 12, long at 20, release at 22.
  task automatic test_reset_mid_hold();
    logic [4:0] exp_ev;
    logic [1:0] exp_st;
    for (int k = 0; k < 26; k++) begin
      r_btn0  = (k < 22);
      i_reset = (k == 10 || k == 11);
      tick();
      case (k)
        0, 12:   exp_ev = EV_P;
        8, 20:   exp_ev = EV_L;
        22:      exp_ev = EV_X;
        default: exp_ev = EV_NONE;
      endcase
      exp_st = (k < 8) ? 2'd1 : (k < 10) ? 2'd2 : (k < 12) ? 2'd0 :
               (k < 20) ? 2'd1 : (k < 22) ? 2'd2 : 2'd0;
      n_checks++;
      if (w_ev0 !== exp_ev || state0 !== exp_st) begin
        n_errors++;
        $display("FAIL reset_mid_hold k=%0d got ev=%b st=%0d want ev=%b st=%0d", k, w_ev0, state0, exp_ev, exp_st);
      end
    end
    i_reset = 1'b0;
  endtask

  // Release and immediate re-press: each press is seen as a new rise.
  task automatic test_back_to_back();
    logic [4:0] exp_ev;
    logic [1:0] exp_st;
    for (int k = 0; k < 6; k++) begin
      r_btn0 = (k == 0 || k == 2 || k == 3);
      tick();
      exp_ev = (k == 0 || k == 2) ? EV_P : (k == 1 || k == 4) ? (EV_S | EV_X) : EV_NONE;
      exp_st = (k == 0 || k == 2 || k == 3) ? 2'd1 : 2'd0;
      n_checks++;
      if (w_ev0 !== exp_ev || state0 !== exp_st) begin
        n_errors++;
        $display("FAIL back_to_back k=%0d got ev=%b st=%0d want ev=%b st=%0d", k, w_ev0, state0, exp_ev, exp_st);
      end
    end
  endtask

  // 6: REPEAT_EN=0: 30-edge hold gives one long and no repeats; then a
  //    1-cycle press gives short+release right after press.
  task automatic test_no_repeat();
    logic [4:0] exp_ev;
    logic [1:0] exp_st;
    for (int k = 0; k < 33; k++) begin
      r_btn1 = (k < 30);
      tick();
      exp_ev = (k == 0) ? EV_P : (k == 8) ? EV_L : (k == 30) ? EV_X : EV_NONE;
      exp_st = (k < 8) ? 2'd1 : (k < 30) ? 2'd2 : 2'd0;
      n_checks++;
      if (w_ev1 !== exp_ev || state1 !== exp_st) begin
        n_errors++;
        $display("FAIL no_repeat_hold k=%0d got ev=%b st=%0d want ev=%b st=%0d", k, w_ev1, state1, exp_ev, exp_st);
      end
    end
    for (int k = 0; k < 4; k++) begin
      r_btn1 = (k < 1);
      tick();
      exp_ev = (k == 0) ? EV_P : (k == 1) ? (EV_S | EV_X) : EV_NONE;
      exp_st = (k < 1) ? 2'd1 : 2'd0;
      n_checks++;
      if (w_ev1 !== exp_ev || state1 !== exp_st) begin
        n_errors++;
        $display("FAIL one_cycle_press k=%0d got ev=%b st=%0d want ev=%b st=%0d", k, w_ev1, state1, exp_ev, exp_st);
      end
    end
  endtask

  initial begin
    test_reset();
    idle(2);
    test_short_press();
    idle(2);
    test_long_repeat();
    idle(2);
    test_long_boundary();
    idle(2);
    test_reset_mid_hold();
    idle(2);
    test_back_to_back();
    idle(2);
    test_no_repeat();
    idle(2);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_button_event_decoder
